// File: rtl/tt_sweep_pkg.sv
//------------------------------------------------------------------------------
// Module   : tt_sweep_pkg
// Purpose  : Shared widths and FSM state encoding for the truth-table sweeper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tt_sweep_pkg;

    localparam int N_IN  = 4;   // inputs of the logic under test
    localparam int N_OUT = 2;   // outputs of the logic under test
    localparam int TBL_W = 32;  // 2**N_IN entries of N_OUT bits
    localparam int CNT_W = 5;   // mismatch counter, must reach 16

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tt_sweep_dly.sv
//------------------------------------------------------------------------------
// Module   : tt_sweep_dly
// Purpose  : LAT-deep delay line carrying the issued index and its valid bit,
//            so each response is paired with the index that produced it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tt_sweep_dly
    import tt_sweep_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] idx_i,
    input  logic            vld_i,
    output logic [N_IN-1:0] idx_o,
    output logic            vld_o
);

    generate
        if (LAT == 0) begin : g_pass
            // No latency: the response belongs to the index issued this cycle.
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign idx_o    = idx_i;
            assign vld_o    = vld_i;
        end else begin : g_pipe
            logic [N_IN-1:0] idx_q [LAT];
            logic [LAT-1:0]  vld_q;

            // Shift index and valid together, one stage per cycle of latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        idx_q[i] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    idx_q[0] <= idx_i;
                    vld_q[0] <= vld_i;
                    for (int i = 1; i < LAT; i++) begin
                        idx_q[i] <= idx_q[i-1];
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            assign idx_o = idx_q[LAT-1];
            assign vld_o = vld_q[LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tt_sweep.sv
//------------------------------------------------------------------------------
// Module   : tt_sweep
// Purpose  : Drives all 16 input codes into a small combinational block,
//            captures its 2-bit responses into a truth table and compares
//            the table against a golden one latched at start.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [TBL_W-1:0]  golden_i,
    output logic [N_IN-1:0]   x_o,
    input  logic [N_OUT-1:0]  y_i,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [TBL_W-1:0]  table_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  mism_cnt_o,
    output logic [N_IN-1:0]   first_mism_o
);

    // Last value of the drain counter; only meaningful when LAT > 0.
    localparam logic [1:0]      c_drain_last = (LAT > 0) ? 2'(LAT - 1) : 2'd0;
    localparam logic [N_IN-1:0] c_idx_last   = {N_IN{1'b1}};

    state_e             state_q;
    logic [N_IN-1:0]    cnt_q;
    logic [1:0]         drain_q;
    logic [TBL_W-1:0]   golden_q;
    logic [TBL_W-1:0]   table_q;
    logic [CNT_W-1:0]   mism_q;
    logic [CNT_W-1:0]   mism_d;
    logic [N_IN-1:0]    first_q;
    logic               found_q;
    logic               pass_q;
    logic               busy_q;
    logic               valid_q;

    logic [N_IN-1:0]    w_dly_idx;
    logic               w_dly_vld;
    logic [N_OUT-1:0]   w_gold_ent;
    logic               w_mis;

    tt_sweep_dly #(
        .LAT (LAT)
    ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .idx_i (cnt_q),
        .vld_i (state_q == ST_SWEEP),
        .idx_o (w_dly_idx),
        .vld_o (w_dly_vld)
    );

    assign w_gold_ent = golden_q[{w_dly_idx, 1'b0} +: N_OUT];
    assign w_mis      = w_dly_vld && (y_i != w_gold_ent);
    assign mism_d     = mism_q + {{(CNT_W-1){1'b0}}, w_mis};

    // Sequencer plus capture datapath; a start clears the previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            drain_q  <= '0;
            golden_q <= '0;
            table_q  <= '0;
            mism_q   <= '0;
            first_q  <= '0;
            found_q  <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            // Responses arrive LAT cycles after issue, independent of state.
            if (w_dly_vld) begin
                table_q[{w_dly_idx, 1'b0} +: N_OUT] <= y_i;
                mism_q <= mism_d;
                if (w_mis && !found_q) begin
                    first_q <= w_dly_idx;
                    found_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        golden_q <= golden_i;
                        table_q  <= '0;
                        mism_q   <= '0;
                        first_q  <= '0;
                        found_q  <= 1'b0;
                        pass_q   <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (cnt_q == c_idx_last) begin
                        // The counter parks at 15; x_o is gated off outside SWEEP.
                        if (LAT == 0) begin
                            state_q <= ST_REPORT;
                            valid_q <= 1'b1;
                            pass_q  <= (mism_d == '0);
                        end else begin
                            state_q <= ST_DRAIN;
                            drain_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == c_drain_last) begin
                        state_q <= ST_REPORT;
                        valid_q <= 1'b1;
                        pass_q  <= (mism_d == '0);
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (valid_q && res_ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x_o          = (state_q == ST_SWEEP) ? cnt_q : '0;
    assign busy_o       = busy_q;
    assign res_valid_o  = valid_q;
    assign table_o      = table_q;
    assign pass_o       = pass_q;
    assign mism_cnt_o   = mism_q;
    assign first_mism_o = first_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep.sv
//------------------------------------------------------------------------------
// Module   : tb_tt_sweep
// Purpose  : Self-checking bench for tt_sweep at LAT=0 and LAT=2, with the
//            logic under test modelled as a lookup into a 32-bit truth table.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tt_sweep;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start0, start2, rdy0, rdy2;
    logic [31:0] gold0, gold2, fn0, fn2;
    logic [3:0]  x0, x2, first0, first2;
    logic [1:0]  y0, y2, y2a, y2b;
    logic        busy0, busy2, val0, val2, pass0, pass2;
    logic [31:0] tbl0, tbl2;
    logic [4:0]  mism0, mism2;

    int nvec  = 0;
    int nfail = 0;

    // Logic under test for LAT=0: purely combinational lookup.
    assign y0 = fn0[{x0, 1'b0} +: 2];

    // Logic under test for LAT=2: the same lookup registered twice.
    always @(posedge clk) begin
        y2a <= fn2[{x2, 1'b0} +: 2];
        y2b <= y2a;
    end
    assign y2 = y2b;

    tt_sweep #(.LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .golden_i(gold0), .x_o(x0), .y_i(y0),
        .busy_o(busy0), .res_valid_o(val0), .res_ready_i(rdy0), .table_o(tbl0),
        .pass_o(pass0), .mism_cnt_o(mism0), .first_mism_o(first0)
    );

    tt_sweep #(.LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .golden_i(gold2), .x_o(x2), .y_i(y2),
        .busy_o(busy2), .res_valid_o(val2), .res_ready_i(rdy2), .table_o(tbl2),
        .pass_o(pass2), .mism_cnt_o(mism2), .first_mism_o(first2)
    );

    // Reference: entry-by-entry comparison of the truth table with the golden.
    function automatic void model(input logic [31:0] fn, input logic [31:0] gold,
                                  output int mism, output int first);
        mism  = 0;
        first = 0;
        for (int k = 15; k >= 0; k--) begin
            if (fn[2*k +: 2] != gold[2*k +: 2]) begin
                mism++;
                first = k;
            end
        end
    endfunction

    // Runs one full sweep on the selected instance (0 or 2) from a negedge.
    // golden_i is scrambled right after acceptance; it must not matter.
    task automatic sweep(input int which, input logic [31:0] fn, input logic [31:0] gold,
                         input int rdy_delay, output int lat, output logic [31:0] tbl,
                         output logic pass, output logic [4:0] mism, output logic [3:0] first,
                         output int xerr, output logic busy_after);
        logic [3:0] xs;
        logic       vs;
        if (which == 0) begin
            fn0 = fn; gold0 = gold; rdy0 = (rdy_delay == 0); start0 = 1'b1;
        end else begin
            fn2 = fn; gold2 = gold; rdy2 = (rdy_delay == 0); start2 = 1'b1;
        end
        @(negedge clk);
        if (which == 0) begin start0 = 1'b0; gold0 = ~gold; end
        else            begin start2 = 1'b0; gold2 = ~gold; end
        lat  = -1;
        xerr = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            xs = (which == 0) ? x0 : x2;
            vs = (which == 0) ? val0 : val2;
            if (int'(xs) != ((n <= 16) ? n - 1 : 0)) xerr++;
            if (vs) begin
                lat = n;
                break;
            end
        end
        tbl   = (which == 0) ? tbl0 : tbl2;
        pass  = (which == 0) ? pass0 : pass2;
        mism  = (which == 0) ? mism0 : mism2;
        first = (which == 0) ? first0 : first2;
        repeat (rdy_delay) @(negedge clk);
        if (which == 0) rdy0 = 1'b1; else rdy2 = 1'b1;
        @(negedge clk);
        busy_after = (which == 0) ? (busy0 | val0) : (busy2 | val2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        nvec++;
        if ({x0, busy0, val0, pass0, mism0, first0} !== 13'd0 || tbl0 !== 32'd0) begin
            nfail++;
            $display("FAIL reset_dut0: x=%0h busy=%0b val=%0b pass=%0b mism=%0d first=%0d tbl=%h, want all 0",
                     x0, busy0, val0, pass0, mism0, first0, tbl0);
        end
        nvec++;
        if ({x2, busy2, val2, pass2, mism2, first2} !== 13'd0 || tbl2 !== 32'd0) begin
            nfail++;
            $display("FAIL reset_dut2: x=%0h busy=%0b val=%0b pass=%0b mism=%0d first=%0d tbl=%h, want all 0",
                     x2, busy2, val2, pass2, mism2, first2, tbl2);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity_pass();
        int lat, xerr; logic [31:0] tbl; logic pass, ba; logic [4:0] mism; logic [3:0] first;
        sweep(0, 32'hE4E4E4E4, 32'hE4E4E4E4, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (lat != 17) begin nfail++; $display("FAIL id_latency: got %0d want 17", lat); end
        nvec++; if (xerr != 0) begin nfail++; $display("FAIL id_x_seq: %0d wrong x_o samples, want 0", xerr); end
        nvec++; if (tbl !== 32'hE4E4E4E4) begin nfail++; $display("FAIL id_table: got %h want e4e4e4e4", tbl); end
        nvec++; if (pass !== 1'b1 || mism !== 5'd0 || first !== 4'd0) begin
            nfail++; $display("FAIL id_result: pass=%0b mism=%0d first=%0d want 1/0/0", pass, mism, first);
        end
        nvec++; if (ba !== 1'b0) begin nfail++; $display("FAIL id_idle_after: busy|valid=%0b want 0", ba); end
    endtask

    task automatic test_single_mism();
        int lat, xerr; logic [31:0] tbl; logic pass, ba; logic [4:0] mism; logic [3:0] first;
        sweep(0, 32'hE4E4E4E4, 32'hE4E4E0E4, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (pass !== 1'b0 || mism !== 5'd1 || first !== 4'd5) begin
            nfail++; $display("FAIL one_mism: pass=%0b mism=%0d first=%0d want 0/1/5", pass, mism, first);
        end
        nvec++; if (tbl !== 32'hE4E4E4E4 || lat != 17) begin
            nfail++; $display("FAIL one_mism_tbl: tbl=%h lat=%0d want e4e4e4e4/17", tbl, lat);
        end
    endtask

    task automatic test_lat2();
        int lat, xerr; logic [31:0] tbl; logic pass, ba; logic [4:0] mism; logic [3:0] first;
        sweep(2, 32'hE4E4E4E4, 32'hE4E4E4E4, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (lat != 19) begin nfail++; $display("FAIL lat2_latency: got %0d want 19", lat); end
        nvec++; if (xerr != 0) begin nfail++; $display("FAIL lat2_x_seq: %0d wrong x_o samples, want 0", xerr); end
        nvec++; if (pass !== 1'b1 || mism !== 5'd0 || tbl !== 32'hE4E4E4E4) begin
            nfail++; $display("FAIL lat2_result: pass=%0b mism=%0d tbl=%h want 1/0/e4e4e4e4", pass, mism, tbl);
        end
        nvec++; if (ba !== 1'b0) begin nfail++; $display("FAIL lat2_idle_after: busy|valid=%0b want 0", ba); end
    endtask

    task automatic test_all_mism();
        int lat, xerr; logic [31:0] tbl; logic pass, ba; logic [4:0] mism; logic [3:0] first;
        sweep(0, 32'hE4E4E4E4, 32'h1B1B1B1B, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (pass !== 1'b0 || mism !== 5'd16 || first !== 4'd0) begin
            nfail++; $display("FAIL all_mism0: pass=%0b mism=%0d first=%0d want 0/16/0", pass, mism, first);
        end
        sweep(2, 32'hE4E4E4E4, 32'h1B1B1B1B, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (pass !== 1'b0 || mism !== 5'd16 || first !== 4'd0) begin
            nfail++; $display("FAIL all_mism2: pass=%0b mism=%0d first=%0d want 0/16/0", pass, mism, first);
        end
    endtask

    task automatic test_backpressure();
        int n, bad;
        fn0 = 32'hE4E4E4E4; gold0 = 32'hE4E4E0E4; rdy0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!val0 && n < 40) begin @(negedge clk); n++; end
        nvec++; if (!val0) begin nfail++; $display("FAIL bp_valid: res_valid_o never rose within 40 cycles"); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            start0 = (i == 2);
            @(negedge clk);
            if (val0 !== 1'b1 || busy0 !== 1'b1 || x0 !== 4'd0 || tbl0 !== 32'hE4E4E4E4 ||
                pass0 !== 1'b0 || mism0 !== 5'd1 || first0 !== 4'd5) bad++;
        end
        nvec++; if (bad != 0) begin nfail++; $display("FAIL bp_stable: %0d unstable cycles while waiting, want 0", bad); end
        // Ready and a start together: the start lands on the handshake cycle.
        rdy0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        nvec++; if (busy0 !== 1'b0 || val0 !== 1'b0) begin
            nfail++; $display("FAIL bp_handshake: busy=%0b val=%0b want 0/0", busy0, val0);
        end
        // start_i still high in the first IDLE cycle: it must be taken now.
        @(negedge clk);
        start0 = 1'b0;
        nvec++; if (busy0 !== 1'b1 || x0 !== 4'd0) begin
            nfail++; $display("FAIL bp_restart: busy=%0b x=%0d want 1/0", busy0, x0);
        end
        n = 1;
        while (!val0 && n < 40) begin @(negedge clk); n++; end
        nvec++; if (n != 17 || pass0 !== 1'b0 || mism0 !== 5'd1) begin
            nfail++; $display("FAIL bp_second: lat=%0d pass=%0b mism=%0d want 17/0/1", n, pass0, mism0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, bad, lat, xerr; logic [31:0] tbl; logic pass, ba; logic [4:0] mism; logic [3:0] first;
        fn0 = 32'hE4E4E4E4; gold0 = 32'h1B1B1B1B; rdy0 = 1'b1; start0 = 1'b1;
        fn2 = 32'hE4E4E4E4; gold2 = 32'h1B1B1B1B; rdy2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        n = 0;
        while (x0 != 4'd7 && n < 30) begin @(negedge clk); n++; end
        nvec++; if (x0 !== 4'd7) begin nfail++; $display("FAIL rmid_reach7: x0=%0d want 7", x0); end
        rst = 1'b1;
        #1;
        nvec++;
        if ({x0, busy0, val0, pass0, mism0, first0} !== 13'd0 || tbl0 !== 32'd0) begin
            nfail++;
            $display("FAIL rmid_dut0: x=%0h busy=%0b val=%0b pass=%0b mism=%0d first=%0d tbl=%h, want all 0",
                     x0, busy0, val0, pass0, mism0, first0, tbl0);
        end
        nvec++;
        if ({x2, busy2, val2, pass2, mism2, first2} !== 13'd0 || tbl2 !== 32'd0) begin
            nfail++;
            $display("FAIL rmid_dut2: x=%0h busy=%0b val=%0b pass=%0b mism=%0d first=%0d tbl=%h, want all 0",
                     x2, busy2, val2, pass2, mism2, first2, tbl2);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (val0 || val2 || busy0 || busy2) bad++;
        end
        nvec++; if (bad != 0) begin nfail++; $display("FAIL rmid_no_result: %0d cycles busy/valid after abort, want 0", bad); end
        sweep(0, 32'hE4E4E4E4, 32'hE4E4E4E4, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (lat != 17 || pass !== 1'b1 || tbl !== 32'hE4E4E4E4 || xerr != 0) begin
            nfail++; $display("FAIL rmid_restart0: lat=%0d pass=%0b tbl=%h xerr=%0d want 17/1/e4e4e4e4/0", lat, pass, tbl, xerr);
        end
        sweep(2, 32'hE4E4E4E4, 32'hE4E4E4E4, 0, lat, tbl, pass, mism, first, xerr, ba);
        nvec++; if (lat != 19 || pass !== 1'b1 || tbl !== 32'hE4E4E4E4 || xerr != 0) begin
            nfail++; $display("FAIL rmid_restart2: lat=%0d pass=%0b tbl=%h xerr=%0d want 19/1/e4e4e4e4/0", lat, pass, tbl, xerr);
        end
    endtask

    task automatic test_random();
        int lat, xerr, m_mism, m_first, which, rd;
        logic [31:0] tbl, fn, gold; logic pass, ba; logic [4:0] mism; logic [3:0] first;
        for (int it = 0; it < 16; it++) begin
            which = (it % 2 == 0) ? 0 : 2;
            fn    = $urandom;
            gold  = fn;
            if (it % 4 != 1) begin
                for (int k = 0; k < 16; k++) begin
                    if ($urandom_range(0, 3) == 0) gold[2*k +: 2] = gold[2*k +: 2] ^ 2'($urandom_range(1, 3));
                end
            end
            rd = $urandom_range(0, 3);
            sweep(which, fn, gold, rd, lat, tbl, pass, mism, first, xerr, ba);
            model(fn, gold, m_mism, m_first);
            nvec++; if (lat != 17 + which) begin nfail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, 17 + which); end
            nvec++; if (tbl !== fn) begin nfail++; $display("FAIL rnd%0d_table: got %h want %h", it, tbl, fn); end
            nvec++; if (mism !== 5'(m_mism) || first !== 4'(m_first) || pass !== (m_mism == 0)) begin
                nfail++; $display("FAIL rnd%0d_result: mism=%0d first=%0d pass=%0b want %0d/%0d/%0b",
                                  it, mism, first, pass, m_mism, m_first, (m_mism == 0));
            end
            nvec++; if (xerr != 0 || ba !== 1'b0) begin
                nfail++; $display("FAIL rnd%0d_seq: xerr=%0d busy_after=%0b want 0/0", it, xerr, ba);
            end
        end
    endtask

    initial begin
        start0 = 1'b0; start2 = 1'b0; rdy0 = 1'b1; rdy2 = 1'b1;
        gold0 = '0; gold2 = '0; fn0 = '0; fn2 = '0;
        test_reset();
        test_identity_pass();
        test_single_mism();
        test_lat2();
        test_all_mism();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 The block SHALL have parameter LAT, default 0, giving the cycles from x_o driven to the matching y_i valid (range 0..3).
REQ-002 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1, a sweep request.
REQ-005 The block SHALL have port golden_i, input, 32, the expected truth table, sampled on start acceptance.
REQ-006 The block SHALL have port x_o, output, 4, the stimulus to the combinational logic under test.
REQ-007 The block SHALL have port y_i, input, 2, the response of the logic under test.
REQ-008 The block SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-009 The block SHALL have port res_valid_o, output, 1, result valid.
REQ-010 The block SHALL have port res_ready_i, input, 1, result accepted by the consumer.
REQ-011 The block SHALL have port table_o, output, 32, the captured truth table, with entry k at bits [2k+1:2k].
REQ-012 The block SHALL have port pass_o, output, 1, high when the captured table equals the golden table.
REQ-013 The block SHALL have port mism_cnt_o, output, 5, the number of mismatching entries (0..16).
REQ-014 The block SHALL have port first_mism_o, output, 4, the lowest mismatching index, or 0 when pass_o is high.

Function
REQ-015 The FSM SHALL have states IDLE, SWEEP, DRAIN, REPORT.
REQ-016 In IDLE, the block SHALL accept start_i on cycle t, latch golden_i, clear the table, clear mism_cnt and clear the first-mismatch flag.
REQ-017 After acceptance, the FSM SHALL go to SWEEP.
REQ-018 In SWEEP, x_o SHALL equal k on cycle t+1+k for k=0..15.
REQ-019 In SWEEP, the 4-bit counter SHALL stop at 15 and SHALL NOT wrap.
REQ-020 Index k SHALL be captured from y_i on cycle t+1+k+LAT, using an LAT-deep shift register of the index and a valid bit.
REQ-021 With LAT=0, capture SHALL occur in the same cycle as x_o=k.
REQ-022 After k=15 is issued, the FSM SHALL enter DRAIN when LAT>0, or go straight to REPORT when LAT=0.
REQ-023 DRAIN SHALL last LAT cycles.
REQ-024 For each captured index k, the block SHALL write table[2k+1:2k]=y_i.
REQ-025 If y_i differs from golden[2k+1:2k], the block SHALL increment mism_cnt.
REQ-026 first_mism SHALL latch only the first mismatching k.
REQ-027 res_valid_o SHALL rise on cycle t+17+LAT.
REQ-028 table_o, pass_o, mism_cnt_o and first_mism_o SHALL be stable while res_valid_o is high.
REQ-029 In REPORT, the block SHALL hold until res_valid_o and res_ready_i are both high, then return to IDLE on the next cycle.
REQ-030 res_valid_o SHALL NOT drop before the handshake completes.
REQ-031 If res_ready_i is already high when res_valid_o rises, the result SHALL transfer in one cycle.
REQ-032 start_i SHALL be ignored while busy_o is high, including on the handshake cycle.
REQ-033 A new start SHALL be accepted in the first IDLE cycle.
REQ-034 Outside SWEEP, x_o SHALL be 0.
REQ-035 A change of golden_i after acceptance SHALL have no effect on the current sweep.
REQ-036 pass_o SHALL equal (mism_cnt==0).
REQ-037 mism_cnt SHALL reach 16 without overflow.

Reset
REQ-038 On rst assertion, the state SHALL go to IDLE immediately.
REQ-039 On rst assertion, x_o, busy_o, res_valid_o, table_o, mism_cnt_o and first_mism_o SHALL become 0.
REQ-040 On rst assertion, pass_o SHALL become 0.
REQ-041 On rst assertion, the latched golden table and the index pipeline SHALL clear.
REQ-042 Reset asserted mid-SWEEP or mid-REPORT SHALL abort the operation with no result produced.
REQ-043 The first start after release SHALL behave exactly as a start from power-up.

Structure
REQ-044 A shared package SHALL hold the FSM state enum, N_IN=4, N_OUT=2, TBL_W=32 and CNT_W=5.
REQ-045 The LAT-deep index/valid delay line SHALL be a sub-module named tt_sweep_dly.
REQ-046 tt_sweep_dly SHALL be a pure pass-through when LAT=0.
REQ-047 Everything else SHALL be a single FSM plus datapath in tt_sweep.

Verification
REQ-048 The bench SHALL cover: LAT=0, DUT y=x[1:0], golden 0xE4E4E4E4, start at cycle 0, res_ready_i=1 -> res_valid_o at cycle 17, pass_o=1, mism_cnt_o=0, table_o=0xE4E4E4E4.
REQ-049 The bench SHALL cover: same DUT, golden 0xE4E4E0E4 -> pass_o=0, mism_cnt_o=1, first_mism_o=5.
REQ-050 The bench SHALL cover: LAT=2, DUT registered twice, golden 0xE4E4E4E4 -> res_valid_o at cycle 19, pass_o=1.
REQ-051 The bench SHALL cover: golden 0x1B1B1B1B against y=x[1:0] -> mism_cnt_o=16, first_mism_o=0.
REQ-052 The bench SHALL cover: res_ready_i held low for 5 cycles, start_i pulsed during REPORT -> outputs stable, no restart, IDLE one cycle after ready.
REQ-053 The bench SHALL cover: rst pulsed at x_o=7 -> all outputs 0 immediately, no res_valid_o; a following start completes normally.
